lzc_norm_shifter: RTL and testbench

Multi-cycle normalizing shifter that consumes an operand together with the zero count produced for it by the leading/trailing-zero counter and shifts the operand so its first set bit lands at the MSB (leading mode) or LSB (trailing mode). It sits directly downstream of the zero counter in FPU normalization and alignment paths. It processes one binary shift stage per cycle, which keeps area low, and uses valid/ready handshakes on both sides.

---
 rtl/lzc_norm_pkg.sv | 15 +
 rtl/lzc_norm_stage.sv | 49 ++++
 rtl/lzc_norm_shifter.sv | 147 ++++++++++++++
 tb/tb_lzc_norm_shifter.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lzc_norm_pkg.sv
// Shared types and sizing for the normalizing shifter.
// The count width here follows the same rule as the upstream zero counter.
package lzc_norm_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    function automatic int cnt_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/lzc_norm_stage.sv
// One binary shift stage: shifts by 2^s when enabled, zero fill.
// With LZC_NORM_STICKY_EN defined it also reports the OR of the bits pushed out.
module lzc_norm_stage
    import lzc_norm_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int CNT_WIDTH = cnt_width(WIDTH),
    parameter int S_WIDTH   = cnt_width(CNT_WIDTH)
) (
    input  logic [WIDTH-1:0]   data,
    input  logic [S_WIDTH-1:0] s,
    input  logic               en,
    input  logic               mode,
    output logic [WIDTH-1:0]   shifted
`ifdef LZC_NORM_STICKY_EN
    ,
    output logic               lost
`endif
);

    logic [CNT_WIDTH-1:0] amt_s;

    // Stage shift: left for leading mode, right for trailing mode
    always_comb begin
        amt_s = CNT_WIDTH'(1) << s;
        if (!en) begin
            shifted = data;
        end else if (mode) begin
            shifted = data << amt_s;
        end else begin
            shifted = data >> amt_s;
        end
    end

`ifdef LZC_NORM_STICKY_EN
    logic [WIDTH-1:0] keep_s;

    // Bits outside keep_s are the ones this stage discards
    always_comb begin
        if (mode) begin
            keep_s = {WIDTH{1'b1}} >> amt_s;
        end else begin
            keep_s = {WIDTH{1'b1}} << amt_s;
        end
        lost = en & (|(data & ~keep_s));
    end
`endif

endmodule

// File: rtl/lzc_norm_shifter.sv
// Multi-cycle normalizing shifter, one binary stage per cycle, valid/ready on both sides.
// Optional sticky accumulation of shifted-out bits under LZC_NORM_STICKY_EN.
module lzc_norm_shifter
    import lzc_norm_pkg::*;
#(
    parameter int   WIDTH     = 32,
    parameter logic MODE      = 1'b0,
    localparam int  CNT_WIDTH = cnt_width(WIDTH)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [WIDTH-1:0]     data_i,
    input  logic [CNT_WIDTH-1:0] cnt_i,
    input  logic                 empty_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [WIDTH-1:0]     data_o,
    output logic                 zero_o,
    output logic                 sticky_o
);

    localparam int S_WIDTH = cnt_width(CNT_WIDTH);
    localparam logic [S_WIDTH-1:0] LAST_S = S_WIDTH'(CNT_WIDTH - 1);

    state_t               state_r;
    state_t               next_state_s;
    logic [WIDTH-1:0]     data_r;
    logic [WIDTH-1:0]     stage_data_s;
    logic [CNT_WIDTH-1:0] cnt_r;
    logic [S_WIDTH-1:0]   s_r;
    logic                 zero_r;
    logic                 stage_en_s;

    assign stage_en_s  = cnt_r[s_r];
    assign in_ready_o  = (state_r == IDLE) && !rst_i;
    assign out_valid_o = (state_r == DONE);
    assign data_o      = data_r;
    assign zero_o      = zero_r;

`ifdef LZC_NORM_STICKY_EN
    logic stage_lost_s;
    logic sticky_r;
`endif

    lzc_norm_stage #(
        .WIDTH     (WIDTH),
        .CNT_WIDTH (CNT_WIDTH),
        .S_WIDTH   (S_WIDTH)
    ) u_stage (
        .data    (data_r),
        .s       (s_r),
        .en      (stage_en_s),
        .mode    (MODE),
        .shifted (stage_data_s)
`ifdef LZC_NORM_STICKY_EN
        ,
        .lost    (stage_lost_s)
`endif
    );

    // FSM state register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic; every stage runs regardless of its count bit so latency is fixed
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (in_valid_i) begin
                    next_state_s = empty_i ? DONE : SHIFT;
                end else begin
                    next_state_s = IDLE;
                end
            end
            SHIFT: begin
                if (s_r == LAST_S) begin
                    next_state_s = DONE;
                end else begin
                    next_state_s = SHIFT;
                end
            end
            DONE: begin
                if (out_ready_i) begin
                    next_state_s = IDLE;
                end else begin
                    next_state_s = DONE;
                end
            end
            default: next_state_s = IDLE;
        endcase
    end

    // Operand capture and per-stage update; DONE holds everything stable
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            data_r <= '0;
            cnt_r  <= '0;
            zero_r <= 1'b0;
            s_r    <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid_i) begin
                        data_r <= empty_i ? '0 : data_i;
                        cnt_r  <= cnt_i;
                        zero_r <= empty_i;
                        s_r    <= '0;
                    end
                end
                SHIFT: begin
                    data_r <= stage_data_s;
                    s_r    <= (s_r == LAST_S) ? '0 : s_r + S_WIDTH'(1);
                end
                default: begin
                end
            endcase
        end
    end

`ifdef LZC_NORM_STICKY_EN
    // Sticky accumulator: cleared on accept, ORs in each stage's discarded bits
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sticky_r <= 1'b0;
        end else if (state_r == IDLE && in_valid_i) begin
            sticky_r <= 1'b0;
        end else if (state_r == SHIFT) begin
            sticky_r <= sticky_r | stage_lost_s;
        end else begin
            sticky_r <= sticky_r;
        end
    end

    assign sticky_o = sticky_r;
`else
    assign sticky_o = 1'b0;
`endif

endmodule

// File: tb/tb_lzc_norm_shifter.sv
// Scoreboard bench for lzc_norm_shifter: WIDTH=8 leading, WIDTH=8 trailing, WIDTH=24 leading.
module tb_lzc_norm_shifter;

`ifdef LZC_NORM_STICKY_EN
    localparam logic STK = 1'b1;
`else
    localparam logic STK = 1'b0;
`endif

    typedef struct {
        logic [23:0] data;
        logic        zero;
        logic        sticky;
        int          acc;
        int          lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   checks = 0;
    int   passed = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic       v0, rdy0, ov0, or0, z0, st0, e0;
    logic [7:0] d0, do0;
    logic [2:0] c0;
    logic       v1, rdy1, ov1, or1, z1, st1, e1;
    logic [7:0] d1, do1;
    logic [2:0] c1;
    logic        v2, rdy2, ov2, or2, z2, st2, e2;
    logic [23:0] d2, do2;
    logic [4:0]  c2;

    exp_t sb0[$], sb1[$], sb2[$];
    exp_t x0, x1, x2;
    logic pv0 = 1'b0, pv1 = 1'b0, pv2 = 1'b0;

    lzc_norm_shifter #(.WIDTH(8), .MODE(1'b1)) u_l8 (
        .clk_i(clk), .rst_i(rst), .in_valid_i(v0), .in_ready_o(rdy0), .data_i(d0),
        .cnt_i(c0), .empty_i(e0), .out_valid_o(ov0), .out_ready_i(or0),
        .data_o(do0), .zero_o(z0), .sticky_o(st0));

    lzc_norm_shifter #(.WIDTH(8), .MODE(1'b0)) u_t8 (
        .clk_i(clk), .rst_i(rst), .in_valid_i(v1), .in_ready_o(rdy1), .data_i(d1),
        .cnt_i(c1), .empty_i(e1), .out_valid_o(ov1), .out_ready_i(or1),
        .data_o(do1), .zero_o(z1), .sticky_o(st1));

    lzc_norm_shifter #(.WIDTH(24), .MODE(1'b1)) u_l24 (
        .clk_i(clk), .rst_i(rst), .in_valid_i(v2), .in_ready_o(rdy2), .data_i(d2),
        .cnt_i(c2), .empty_i(e2), .out_valid_o(ov2), .out_ready_i(or2),
        .data_o(do2), .zero_o(z2), .sticky_o(st2));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic cmp(input string tag, input exp_t x, input logic [23:0] d,
                       input logic z, input logic s);
        chk({tag, "_data"}, 32'(d), 32'(x.data));
        chk({tag, "_zero"}, 32'(z), 32'(x.zero));
        chk({tag, "_sticky"}, 32'(s), 32'(x.sticky));
    endtask

    task automatic spurious(input string tag);
        checks++;
        $display("FAIL %s: out_valid high with no pending result (t=%0t)", tag, $time);
    endtask

    // Monitors: latency on the rising output valid, result on the output handshake
    always @(negedge clk) begin
        if (!rst && ov0) begin
            if (sb0.size() == 0) spurious("spur_l8");
            else begin
                if (!pv0) chk("lat_l8", cyc - sb0[0].acc, sb0[0].lat);
                if (or0) begin x0 = sb0.pop_front(); cmp("res_l8", x0, {16'd0, do0}, z0, st0); end
            end
        end
        pv0 <= ov0;
    end

    always @(negedge clk) begin
        if (!rst && ov1) begin
            if (sb1.size() == 0) spurious("spur_t8");
            else begin
                if (!pv1) chk("lat_t8", cyc - sb1[0].acc, sb1[0].lat);
                if (or1) begin x1 = sb1.pop_front(); cmp("res_t8", x1, {16'd0, do1}, z1, st1); end
            end
        end
        pv1 <= ov1;
    end

    always @(negedge clk) begin
        if (!rst && ov2) begin
            if (sb2.size() == 0) spurious("spur_l24");
            else begin
                if (!pv2) chk("lat_l24", cyc - sb2[0].acc, sb2[0].lat);
                if (or2) begin x2 = sb2.pop_front(); cmp("res_l24", x2, do2, z2, st2); end
            end
        end
        pv2 <= ov2;
    end

    function automatic logic rdy(input int k);
        case (k)
            0:       return rdy0;
            1:       return rdy1;
            default: return rdy2;
        endcase
    endfunction

    task automatic drive(input int k, input logic v, input logic [23:0] d,
                         input logic [4:0] c, input logic e);
        case (k)
            0:       begin v0 = v; d0 = d[7:0]; c0 = c[2:0]; e0 = e; end
            1:       begin v1 = v; d1 = d[7:0]; c1 = c[2:0]; e1 = e; end
            default: begin v2 = v; d2 = d;      c2 = c;      e2 = e; end
        endcase
    endtask

    // Issue one operand; acc is the cycle count just after the accepting edge
    task automatic issue(input int k, input logic [23:0] d, input logic [4:0] c, input logic e,
                         input logic [23:0] xd, input logic xz, input logic xs,
                         input bit push, output int acc);
        int   n = 0;
        exp_t x;
        @(negedge clk);
        while (!rdy(k) && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            checks++;
            $display("FAIL accept_timeout: unit %0d in_ready stayed %0b, expected 1", k, rdy(k));
            acc = cyc;
            return;
        end
        drive(k, 1'b1, d, c, e);
        @(posedge clk);
        #1;
        drive(k, 1'b0, d, c, e);
        acc = cyc;
        x = '{xd, xz, xs, acc, e ? 0 : ((k == 2) ? 5 : 3)};
        if (push) begin
            case (k)
                0:       sb0.push_back(x);
                1:       sb1.push_back(x);
                default: sb2.push_back(x);
            endcase
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((sb0.size() != 0 || sb1.size() != 0 || sb2.size() != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            checks++;
            $display("FAIL drain_timeout: pending %0d/%0d/%0d, expected 0/0/0",
                     sb0.size(), sb1.size(), sb2.size());
        end
    endtask

    initial begin
        int acc, prev, n;
        rst = 1'b1;
        drive(0, 1'b0, 24'd0, 5'd0, 1'b0);
        drive(1, 1'b0, 24'd0, 5'd0, 1'b0);
        drive(2, 1'b0, 24'd0, 5'd0, 1'b0);
        or0 = 1'b1; or1 = 1'b1; or2 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", {29'd0, ov0, ov1, ov2}, 32'd0);
        chk("rst_data_l8", 32'(do0), 32'd0);
        chk("rst_data_t8", 32'(do1), 32'd0);
        chk("rst_data_l24", 32'(do2), 32'd0);
        chk("rst_zero", {29'd0, z0, z1, z2}, 32'd0);
        chk("rst_sticky", {29'd0, st0, st1, st2}, 32'd0);
        chk("rst_ready", {29'd0, rdy0, rdy1, rdy2}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", {29'd0, rdy0, rdy1, rdy2}, 32'd7);

        // Leading mode, WIDTH=8
        issue(0, 24'h16, 5'd3, 1'b0, 24'hB0, 1'b0, 1'b0, 1'b1, acc);
        issue(0, 24'h01, 5'd7, 1'b0, 24'h80, 1'b0, 1'b0, 1'b1, acc);
        issue(0, 24'h80, 5'd0, 1'b0, 24'h80, 1'b0, 1'b0, 1'b1, acc);
        issue(0, 24'hC0, 5'd1, 1'b0, 24'h80, 1'b0, STK,  1'b1, acc);
        // Trailing mode, WIDTH=8
        issue(1, 24'h68, 5'd3, 1'b0, 24'h0D, 1'b0, 1'b0, 1'b1, acc);
        issue(1, 24'h68, 5'd4, 1'b0, 24'h06, 1'b0, STK,  1'b1, acc);
        issue(1, 24'h80, 5'd7, 1'b0, 24'h01, 1'b0, 1'b0, 1'b1, acc);
        // Back-to-back empties: one every 2 cycles, data forced to zero
        issue(0, 24'h00, 5'd0, 1'b1, 24'h00, 1'b1, 1'b0, 1'b1, acc);
        prev = acc;
        issue(0, 24'hFF, 5'd5, 1'b1, 24'h00, 1'b1, 1'b0, 1'b1, acc);
        chk("empty_ii_1", acc - prev, 2);
        prev = acc;
        issue(0, 24'h00, 5'd0, 1'b1, 24'h00, 1'b1, 1'b0, 1'b1, acc);
        chk("empty_ii_2", acc - prev, 2);
        // WIDTH=24: non-power-of-two width, over-range shift flushes to zero
        issue(2, 24'h000001, 5'd23, 1'b0, 24'h800000, 1'b0, 1'b0, 1'b1, acc);
        issue(2, 24'h000001, 5'd31, 1'b0, 24'h000000, 1'b0, STK,  1'b1, acc);
        issue(2, 24'h800000, 5'd0,  1'b0, 24'h800000, 1'b0, 1'b0, 1'b1, acc);
        drain();

        // Backpressure in DONE with stray in_valid pulses
        or1 = 1'b0;
        issue(1, 24'h68, 5'd3, 1'b0, 24'h0D, 1'b0, 1'b0, 1'b1, acc);
        n = 0;
        while (!ov1 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 20) begin
            checks++;
            $display("FAIL stall_valid_timeout: out_valid %0b, expected 1", ov1);
        end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("stall_valid", 32'(ov1), 32'd1);
            chk("stall_data", 32'(do1), 32'h0D);
            chk("stall_ready", 32'(rdy1), 32'd0);
            v1 = (i == 0 || i == 2);
            d1 = 8'hFF;
            c1 = 3'd1;
        end
        or1 = 1'b1;
        drain();
        @(posedge clk);
        #1;
        chk("post_stall_valid", 32'(ov1), 32'd0);
        chk("post_stall_ready", 32'(rdy1), 32'd1);

        // Reset while at stage s=1; the in-flight operand must vanish
        issue(0, 24'h16, 5'd3, 1'b0, 24'h00, 1'b0, 1'b0, 1'b0, acc);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_valid", 32'(ov0), 32'd0);
        chk("midrst_data", 32'(do0), 32'd0);
        chk("midrst_zero", 32'(z0), 32'd0);
        chk("midrst_sticky", 32'(st0), 32'd0);
        chk("midrst_ready", 32'(rdy0), 32'd0);
        rst = 1'b0;
        #1;
        chk("midrst_ready_after", 32'(rdy0), 32'd1);
        issue(0, 24'h16, 5'd3, 1'b0, 24'hB0, 1'b0, 1'b0, 1'b1, acc);
        drain();
        repeat (3) @(posedge clk);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
